// File: rtl/lamp_pkg.sv
// rtl/lamp_pkg.sv - lamp encodings and FSM state codes shared by the intersection controller
// Contents: RED/YELLOW/GREEN one-hot lamp constants, state_t phase codes 0..5.
package lamp_pkg;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    // Codes 6 and 7 are unused; the controller treats them as illegal.
    typedef enum logic [2:0] {
        NS_GRN   = 3'd0,
        NS_YEL   = 3'd1,
        AR_TO_EW = 3'd2,
        EW_GRN   = 3'd3,
        EW_YEL   = 3'd4,
        AR_TO_NS = 3'd5
    } state_t;

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - saturating dwell counter for one FSM phase
// Ports: clk, rst (sync, active-high), clr (restart on state entry), tick_en (dwell strobe),
//        dur (phase duration in ticks, >=1), cnt (ticks elapsed, saturates at dur-1),
//        expired (tick_en on the last tick of the phase).
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             tick_en,
    input  logic [CNT_W:0]   dur,
    output logic [CNT_W-1:0] cnt,
    output logic             expired
);

    // dur is one bit wider than cnt so a duration of exactly 2^CNT_W fits;
    // its final count dur-1 always fits in CNT_W bits.
    logic [CNT_W:0] last;
    logic           at_last;

    assign last    = dur - (CNT_W+1)'(1);
    assign at_last = ({1'b0, cnt} == last);
    assign expired = tick_en && at_last;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (tick_en && !at_last) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/traffic_controller.sv
// rtl/traffic_controller.sv - two-approach intersection controller with NS rest and EW on request
// Ports: clk, rst (sync, active-high), tick_en (dwell strobe), ew_req (EW vehicle sensor),
//        ns_light / ew_light (one-hot lamp heads: 100 red, 010 yellow, 001 green),
//        phase (current state code), ew_pend (latched EW request).
module traffic_controller
    import lamp_pkg::*;
#(
    parameter int GREEN_TICKS  = 8,
    parameter int YELLOW_TICKS = 2,
    parameter int ALLRED_TICKS = 1,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_en,
    input  logic       ew_req,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic [2:0] phase,
    output logic       ew_pend
);

    localparam logic [CNT_W:0] GREEN_DUR  = (CNT_W+1)'(GREEN_TICKS);
    localparam logic [CNT_W:0] YELLOW_DUR = (CNT_W+1)'(YELLOW_TICKS);
    localparam logic [CNT_W:0] ALLRED_DUR = (CNT_W+1)'(ALLRED_TICKS);

    state_t           state;
    state_t           state_next;
    logic [CNT_W:0]   dur;
    logic             expired;
    logic             clr;
    logic [CNT_W-1:0] dwell_cnt_unused;  // count is kept for debug probing only

    // Restart the dwell count on every edge that changes state.
    assign clr = (state_next != state);

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .tick_en (tick_en),
        .dur     (dur),
        .cnt     (dwell_cnt_unused),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= AR_TO_NS;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        dur        = ALLRED_DUR;
        state_next = state;
        case (state)
            NS_GRN: begin
                dur = GREEN_DUR;
                // Without a pending request NS rests here with cnt saturated.
                if (expired && ew_pend) state_next = NS_YEL;
            end
            NS_YEL: begin
                dur = YELLOW_DUR;
                if (expired) state_next = AR_TO_EW;
            end
            AR_TO_EW: begin
                if (expired) state_next = EW_GRN;
            end
            EW_GRN: begin
                dur = GREEN_DUR;
                if (expired) state_next = EW_YEL;
            end
            EW_YEL: begin
                dur = YELLOW_DUR;
                if (expired) state_next = AR_TO_NS;
            end
            AR_TO_NS: begin
                if (expired) state_next = NS_GRN;
            end
            // Illegal codes recover immediately, independent of tick_en.
            default: state_next = AR_TO_NS;
        endcase
    end

    // Request latch: serving EW clears it, and that clear beats a same-cycle request.
    always_ff @(posedge clk) begin
        if (rst) begin
            ew_pend <= 1'b0;
        end else if (state == AR_TO_EW && state_next == EW_GRN) begin
            ew_pend <= 1'b0;
        end else if (ew_req) begin
            ew_pend <= 1'b1;
        end
    end

    always_comb begin
        ns_light = RED;
        ew_light = RED;
        case (state)
            NS_GRN:  ns_light = GREEN;
            NS_YEL:  ns_light = YELLOW;
            EW_GRN:  ew_light = GREEN;
            EW_YEL:  ew_light = YELLOW;
            default: begin
                ns_light = RED;
                ew_light = RED;
            end
        endcase
    end

    assign phase = state;

endmodule

// File: tb/tb_traffic_controller.sv
// tb/tb_traffic_controller.sv - scoreboard bench for traffic_controller phase, lamp and request behaviour
module tb_traffic_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_en = 1'b1;
    logic       ew_req = 1'b0;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic [2:0] phase;
    logic       ew_pend;

    int vectors = 0;
    int miscompares = 0;
    bit chk_on = 1'b0;

    typedef struct {
        logic [2:0] ph;
        logic       pv;
        logic       pend;
    } exp_t;

    exp_t sb[$];

    traffic_controller #(
        .GREEN_TICKS  (4),
        .YELLOW_TICKS (2),
        .ALLRED_TICKS (1),
        .CNT_W        (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick_en  (tick_en),
        .ew_req   (ew_req),
        .ns_light (ns_light),
        .ew_light (ew_light),
        .phase    (phase),
        .ew_pend  (ew_pend)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] ns_of(input logic [2:0] p);
        case (p)
            3'd0:    return 3'b001;
            3'd1:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] ew_of(input logic [2:0] p);
        case (p)
            3'd3:    return 3'b001;
            3'd4:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    // pend: 0/1 expected ew_pend value, 2 = don't care
    task automatic push(input int ph, input int n, input int pend);
        exp_t e;
        e.ph   = 3'(ph);
        e.pv   = (pend != 2);
        e.pend = (pend == 1);
        repeat (n) sb.push_back(e);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        ew_req  = 1'b0;
        tick_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            vectors++;
            lamp_excl: assert (ns_light == 3'b100 || ew_light == 3'b100) else begin
                miscompares++;
                $display("FAIL lamp_excl: ns=%b ew=%b, want at least one head 100", ns_light, ew_light);
            end
        end
    end

    task automatic test_reset();
        exp_t e;
        rst = 1'b1; tick_en = 1'b1; ew_req = 1'b0;
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        push(5, 1, 0);
        e = sb.pop_front();
        vectors++;
        if (phase !== e.ph || ns_light !== ns_of(e.ph) || ew_light !== ew_of(e.ph) || ew_pend !== e.pend) begin
            miscompares++;
            $display("FAIL reset_state: phase/ns/ew/pend=%0d/%b/%b/%b want %0d/%b/%b/%b",
                     phase, ns_light, ew_light, ew_pend, e.ph, ns_of(e.ph), ew_of(e.ph), e.pend);
        end
        rst = 1'b0;
        push(0, 50, 0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (phase !== e.ph || ns_light !== ns_of(e.ph) || ew_light !== ew_of(e.ph) || ew_pend !== e.pend) begin
                miscompares++;
                $display("FAIL ns_rest cyc %0d: phase/ns/ew/pend=%0d/%b/%b/%b want %0d/%b/%b/%b",
                         i, phase, ns_light, ew_light, ew_pend, e.ph, ns_of(e.ph), ew_of(e.ph), e.pend);
            end
        end
    endtask

    task automatic test_ew_pulse();
        exp_t e;
        push(0, 10, 0); push(0, 1, 1); push(1, 2, 1); push(2, 1, 1);
        push(3, 4, 0); push(4, 2, 0); push(5, 1, 0); push(0, 5, 0);
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (phase !== e.ph || ns_light !== ns_of(e.ph) || ew_light !== ew_of(e.ph) || ew_pend !== e.pend) begin
                miscompares++;
                $display("FAIL ew_pulse cyc %0d: phase/ns/ew/pend=%0d/%b/%b/%b want %0d/%b/%b/%b",
                         i, phase, ns_light, ew_light, ew_pend, e.ph, ns_of(e.ph), ew_of(e.ph), e.pend);
            end
            ew_req = (i == 9);
        end
        ew_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        do_reset();
        ew_req = 1'b1;
        for (int r = 0; r < 2; r++) begin
            push(0, 4, 1); push(1, 2, 1); push(2, 1, 1); push(3, 1, 0);
            push(3, 3, 1); push(4, 2, 1); push(5, 1, 1);
        end
        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (phase !== e.ph || ns_light !== ns_of(e.ph) || ew_light !== ew_of(e.ph) || ew_pend !== e.pend) begin
                miscompares++;
                $display("FAIL back_to_back cyc %0d: phase/ns/ew/pend=%0d/%b/%b/%b want %0d/%b/%b/%b",
                         i, phase, ns_light, ew_light, ew_pend, e.ph, ns_of(e.ph), ew_of(e.ph), e.pend);
            end
        end
        ew_req = 1'b0;
    endtask

    task automatic test_tick_third();
        exp_t e;
        do_reset();
        tick_en = 1'b0;
        ew_req  = 1'b1;
        push(5, 3, 1); push(0, 12, 1); push(1, 6, 1); push(2, 3, 1);
        push(3, 12, 0); push(4, 6, 0); push(5, 3, 0); push(0, 3, 0);
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (phase !== e.ph || ns_light !== ns_of(e.ph) || ew_light !== ew_of(e.ph) || ew_pend !== e.pend) begin
                miscompares++;
                $display("FAIL tick_third cyc %0d: phase/ns/ew/pend=%0d/%b/%b/%b want %0d/%b/%b/%b",
                         i, phase, ns_light, ew_light, ew_pend, e.ph, ns_of(e.ph), ew_of(e.ph), e.pend);
            end
            ew_req  = 1'b0;
            tick_en = ((i % 3) == 2);
        end
        tick_en = 1'b1;
    endtask

    task automatic test_freeze();
        exp_t e;
        do_reset();
        ew_req = 1'b1;
        push(0, 4, 1); push(1, 2, 1); push(2, 1, 1); push(3, 24, 0);
        push(4, 2, 0); push(5, 1, 0); push(0, 3, 0);
        for (int i = 0; i < 37; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (phase !== e.ph || ns_light !== ns_of(e.ph) || ew_light !== ew_of(e.ph) || ew_pend !== e.pend) begin
                miscompares++;
                $display("FAIL freeze cyc %0d: phase/ns/ew/pend=%0d/%b/%b/%b want %0d/%b/%b/%b",
                         i, phase, ns_light, ew_light, ew_pend, e.ph, ns_of(e.ph), ew_of(e.ph), e.pend);
            end
            ew_req  = 1'b0;
            tick_en = !(i >= 8 && i <= 27);
        end
        tick_en = 1'b1;
    endtask

    task automatic test_rst_mid();
        exp_t e;
        do_reset();
        ew_req = 1'b1;
        push(0, 4, 1); push(1, 2, 1); push(2, 1, 1); push(3, 1, 0);
        push(3, 1, 1); push(5, 1, 0); push(0, 1, 0);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (phase !== e.ph || ns_light !== ns_of(e.ph) || ew_light !== ew_of(e.ph) || ew_pend !== e.pend) begin
                miscompares++;
                $display("FAIL rst_mid cyc %0d: phase/ns/ew/pend=%0d/%b/%b/%b want %0d/%b/%b/%b",
                         i, phase, ns_light, ew_light, ew_pend, e.ph, ns_of(e.ph), ew_of(e.ph), e.pend);
            end
            ew_req = (i <= 8);
            rst    = (i == 8);
        end
        ew_req = 1'b0;
        rst    = 1'b0;
    endtask

    task automatic test_illegal();
        exp_t e;
        do_reset();
        push(0, 3, 0); push(7, 1, 2); push(5, 2, 0); push(0, 1, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (phase !== e.ph || ns_light !== ns_of(e.ph) || ew_light !== ew_of(e.ph) || (e.pv && ew_pend !== e.pend)) begin
                miscompares++;
                $display("FAIL illegal cyc %0d: phase/ns/ew/pend=%0d/%b/%b/%b want %0d/%b/%b/%b",
                         i, phase, ns_light, ew_light, ew_pend, e.ph, ns_of(e.ph), ew_of(e.ph), e.pend);
            end
            tick_en = (i < 2) || (i >= 4);
            if (i == 2) begin
                force dut.state = lamp_pkg::state_t'(3'd7);
                #1;
                e = sb.pop_front();
                vectors++;
                if (phase !== e.ph || ns_light !== ns_of(e.ph) || ew_light !== ew_of(e.ph)) begin
                    miscompares++;
                    $display("FAIL illegal_decode: phase/ns/ew=%0d/%b/%b want %0d/%b/%b",
                             phase, ns_light, ew_light, e.ph, ns_of(e.ph), ew_of(e.ph));
                end
                #1;
                release dut.state;
            end
        end
        tick_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_ew_pulse();
        test_back_to_back();
        test_tick_third();
        test_freeze();
        test_rst_mid();
        test_illegal();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
